// File: rtl/adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module   : adc_spi_capture
// Brief    : Paces AD7476-class 16-bit SPI conversions (CPOL=1) and presents
//            each 12-bit result with a one-cycle ad_done strobe.
//            Optional 4-sample averaging: define ADC_AVG4_EN.
// Revision : 1.0 - initial release
// ============================================================================
module adc_spi_capture #(
    parameter int CLK_DIV       = 2,
    parameter int SAMPLE_PERIOD = 50000,
    parameter int T_QUIET       = 4
) (
    input  logic        clk_50M,
    input  logic        rst,
    input  logic        en,
    input  logic        adc_sdo,
    output logic        adc_cs_n,
    output logic        adc_sclk,
    output logic [11:0] ad_data,
    output logic        ad_done,
    output logic        busy,
    output logic        frame_err,
    output logic        overrun
);

    localparam int c_DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int c_TMR_W = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
    localparam int c_Q_W   = (T_QUIET > 0) ? $clog2(T_QUIET + 1) : 1;

    localparam logic [c_DIV_W-1:0] c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(SAMPLE_PERIOD - 1);
    localparam logic [c_Q_W-1:0]   c_Q_LAST   = c_Q_W'((T_QUIET > 0) ? T_QUIET - 1 : 0);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_SETUP = 3'd1;
    localparam logic [2:0] c_SHIFT = 3'd2;
    localparam logic [2:0] c_HOLD  = 3'd3;
    localparam logic [2:0] c_QUIET = 3'd4;

    logic [2:0]         r_state;
    logic [c_TMR_W-1:0] r_tmr;
    logic [c_DIV_W-1:0] r_div_cnt;
    logic [4:0]         r_bit_cnt;
    logic [c_Q_W-1:0]   r_q_cnt;
    logic [15:0]        r_shift;

    logic w_tick;
    logic w_div_end;
    logic w_frame_done;
    logic w_err;

    assign w_tick       = en && (r_tmr == '0);
    assign w_div_end    = (r_div_cnt == c_DIV_LAST);
    assign w_frame_done = (r_state == c_HOLD) && w_div_end;
    assign w_err        = |r_shift[15:12];

    // Held at zero while disabled so the first enabled cycle is a tick.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_tmr <= '0;
        end else if (!en) begin
            r_tmr <= '0;
        end else if (r_tmr == c_TMR_LAST) begin
            r_tmr <= '0;
        end else begin
            r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_div_cnt <= '0;
            r_bit_cnt <= '0;
            r_q_cnt   <= '0;
            r_shift   <= '0;
            adc_cs_n  <= 1'b1;
            adc_sclk  <= 1'b1;
            busy      <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_tick) begin
                        r_state   <= c_SETUP;
                        r_div_cnt <= '0;
                        adc_cs_n  <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                c_SETUP: begin
                    if (w_div_end) begin
                        r_state   <= c_SHIFT;
                        r_div_cnt <= '0;
                        r_bit_cnt <= '0;
                        adc_sclk  <= 1'b0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                c_SHIFT: begin
                    if (w_div_end) begin
                        r_div_cnt <= '0;
                        // sdo is captured on the edge that drives sclk high.
                        if (!adc_sclk) begin
                            adc_sclk <= 1'b1;
                            r_shift  <= {r_shift[14:0], adc_sdo};
                        end else if (r_bit_cnt == 5'd15) begin
                            r_state <= c_HOLD;
                        end else begin
                            adc_sclk  <= 1'b0;
                            r_bit_cnt <= r_bit_cnt + 1'b1;
                        end
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                c_HOLD: begin
                    if (w_div_end) begin
                        r_state   <= (T_QUIET > 0) ? c_QUIET : c_IDLE;
                        r_div_cnt <= '0;
                        r_q_cnt   <= '0;
                        adc_cs_n  <= 1'b1;
                        busy      <= 1'b0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 1'b1;
                    end
                end
                c_QUIET: begin
                    if (r_q_cnt == c_Q_LAST) begin
                        r_state <= c_IDLE;
                    end else begin
                        r_q_cnt <= r_q_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            overrun <= 1'b0;
        end else if (!en) begin
            overrun <= 1'b0;
        end else if (w_tick && (r_state != c_IDLE)) begin
            overrun <= 1'b1;
        end
    end

`ifdef ADC_AVG4_EN
    logic [13:0] r_acc;
    logic [1:0]  r_acc_cnt;
    logic        r_acc_err;
    logic [13:0] w_acc_next;

    assign w_acc_next = r_acc + {2'b00, r_shift[11:0]};

    // Partial sums are discarded whenever sampling is disabled.
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            r_acc     <= '0;
            r_acc_cnt <= '0;
            r_acc_err <= 1'b0;
            ad_data   <= '0;
            ad_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ad_done <= 1'b0;
            if (!en) begin
                r_acc     <= '0;
                r_acc_cnt <= '0;
                r_acc_err <= 1'b0;
            end else if (w_frame_done) begin
                if (r_acc_cnt == 2'd3) begin
                    ad_done   <= 1'b1;
                    ad_data   <= w_acc_next[13:2];
                    frame_err <= r_acc_err | w_err;
                    r_acc     <= '0;
                    r_acc_cnt <= '0;
                    r_acc_err <= 1'b0;
                end else begin
                    r_acc     <= w_acc_next;
                    r_acc_cnt <= r_acc_cnt + 1'b1;
                    r_acc_err <= r_acc_err | w_err;
                end
            end
        end
    end
`else
    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            ad_data   <= '0;
            ad_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            ad_done <= w_frame_done;
            if (w_frame_done) begin
                ad_data   <= r_shift[11:0];
                frame_err <= w_err;
            end
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_spi_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_spi_capture
// Brief    : Self-checking bench for adc_spi_capture with an SPI ADC model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_spi_capture;

    localparam int CLK_DIV  = 2;
    localparam int PERIOD_A = 1000;
    localparam int PERIOD_B = 60;
    localparam int T_QUIET  = 4;
    localparam int LATENCY  = 34 * CLK_DIV + 1;

    logic        clk_50M = 1'b0;
    logic        rst     = 1'b1;
    logic        en_a    = 1'b0;
    logic        en_b    = 1'b0;
    logic        sdo_a   = 1'b0;
    logic        sdo_b   = 1'b0;
    logic        cs_n_a, sclk_a, done_a, busy_a, err_a, ovr_a;
    logic        cs_n_b, sclk_b, done_b, busy_b, err_b, ovr_b;
    logic [11:0] data_a, data_b;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int last_done_cyc = 0;

    always #10 clk_50M = ~clk_50M;
    always @(posedge clk_50M) cyc <= cyc + 1;

    adc_spi_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD_A), .T_QUIET(T_QUIET)) u_dut_a (
        .clk_50M(clk_50M), .rst(rst), .en(en_a), .adc_sdo(sdo_a),
        .adc_cs_n(cs_n_a), .adc_sclk(sclk_a), .ad_data(data_a), .ad_done(done_a),
        .busy(busy_a), .frame_err(err_a), .overrun(ovr_a)
    );

    adc_spi_capture #(.CLK_DIV(CLK_DIV), .SAMPLE_PERIOD(PERIOD_B), .T_QUIET(T_QUIET)) u_dut_b (
        .clk_50M(clk_50M), .rst(rst), .en(en_b), .adc_sdo(sdo_b),
        .adc_cs_n(cs_n_b), .adc_sclk(sclk_b), .ad_data(data_b), .ad_done(done_b),
        .busy(busy_b), .frame_err(err_b), .overrun(ovr_b)
    );

    // ADC model: each cs_n fall loads the next queued word, each sclk fall
    // presents the next bit MSB first.
    logic [15:0] frames [64];
    int          wr_idx  = 0;
    int          rd_idx  = 0;
    logic [15:0] cur_sh  = 16'h0;
    logic        sclk_prev = 1'b1;
    int          falls_a = 0;

    always @(negedge cs_n_a or sclk_a) begin
        if (sclk_a !== sclk_prev) begin
            if (sclk_prev === 1'b1 && sclk_a === 1'b0) begin
                sdo_a   = cur_sh[15];
                cur_sh  = cur_sh << 1;
                falls_a = falls_a + 1;
            end
            sclk_prev = sclk_a;
        end else begin
            if (rd_idx < wr_idx) begin
                cur_sh = frames[rd_idx % 64];
                rd_idx = rd_idx + 1;
            end else begin
                cur_sh = 16'h0;
            end
            falls_a = 0;
        end
    end

    task automatic push_frame(input logic [15:0] f);
        frames[wr_idx % 64] = f;
        wr_idx = wr_idx + 1;
    endtask

    task automatic wait_done_a(input int bound, output bit got);
        got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            @(negedge clk_50M);
            if (done_a === 1'b1) got = 1'b1;
        end
    endtask

    task automatic wait_cs_low_a(input int bound, output bit got);
        got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            @(negedge clk_50M);
            if (cs_n_a === 1'b0) got = 1'b1;
        end
    endtask

    task automatic wait_falls_a(input int target, input int bound, output bit got);
        got = 1'b0;
        for (int n = 0; n < bound && !got; n++) begin
            @(negedge clk_50M);
            if (falls_a >= target) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_50M);
        n_checks++;
        if ({cs_n_a, sclk_a, data_a, done_a, busy_a, err_a, ovr_a} !== {1'b1, 1'b1, 12'h000, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_a: got cs=%b sclk=%b data=%h done=%b busy=%b err=%b ovr=%b expected 1 1 000 0 0 0 0",
                     cs_n_a, sclk_a, data_a, done_a, busy_a, err_a, ovr_a);
        end
        n_checks++;
        if ({cs_n_b, sclk_b, data_b, done_b, busy_b, err_b, ovr_b} !== {1'b1, 1'b1, 12'h000, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_b: got cs=%b sclk=%b data=%h done=%b busy=%b err=%b ovr=%b expected 1 1 000 0 0 0 0",
                     cs_n_b, sclk_b, data_b, done_b, busy_b, err_b, ovr_b);
        end
        rst = 1'b0;
        @(negedge clk_50M);
    endtask

    task automatic test_overrun();
        @(negedge clk_50M);
        en_b = 1'b1;
        repeat (30) @(negedge clk_50M);
        n_checks++;
        if (ovr_b !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_early: got %b expected 0", ovr_b);
        end
        repeat (200) @(negedge clk_50M);
        n_checks++;
        if (ovr_b !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: got %b expected 1", ovr_b);
        end
        en_b = 1'b0;
        @(negedge clk_50M);
        n_checks++;
        if (ovr_b !== 1'b0) begin
            n_fail++;
            $display("FAIL overrun_clear: got %b expected 0", ovr_b);
        end
    endtask

    task automatic test_basic();
        logic [15:0] f;
        bit got;
        int t0, lows;
        f = 16'h0ABC;
        push_frame(f);
        @(negedge clk_50M);
        en_a = 1'b1;
        t0   = cyc;
        lows = 0;
        got  = 1'b0;
        for (int n = 0; n < LATENCY + 20 && !got; n++) begin
            @(negedge clk_50M);
            if (cs_n_a === 1'b0) lows++;
            if (done_a === 1'b1) got = 1'b1;
        end
        last_done_cyc = cyc;
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL basic_timeout: no ad_done within %0d cycles", LATENCY + 20);
        end
        n_checks++;
        if (cyc - t0 !== LATENCY) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d", cyc - t0, LATENCY);
        end
        n_checks++;
        if (data_a !== f[11:0] || err_a !== (f[15:12] != 4'h0)) begin
            n_fail++;
            $display("FAIL basic_data: got %h err=%b expected %h err=%b", data_a, err_a, f[11:0], (f[15:12] != 4'h0));
        end
        n_checks++;
        if (lows !== 34 * CLK_DIV) begin
            n_fail++;
            $display("FAIL basic_cs_low: got %0d cycles expected %0d", lows, 34 * CLK_DIV);
        end
        n_checks++;
        if (falls_a !== 16) begin
            n_fail++;
            $display("FAIL basic_sclk_falls: got %0d expected 16", falls_a);
        end
        n_checks++;
        if (cs_n_a !== 1'b1 || busy_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_idle_at_done: got cs=%b busy=%b expected 1 0", cs_n_a, busy_a);
        end
        @(negedge clk_50M);
        n_checks++;
        if (done_a !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_done_width: got %b expected 0", done_a);
        end
    endtask

    task automatic test_frame_err();
        logic [15:0] fs [2];
        bit got;
        fs[0] = 16'h8123;
        fs[1] = 16'h0001;
        for (int i = 0; i < 2; i++) begin
            push_frame(fs[i]);
            wait_done_a(PERIOD_A + 20, got);
            n_checks++;
            if (!got) begin
                n_fail++;
                $display("FAIL frame_err_timeout[%0d]: no ad_done", i);
            end
            n_checks++;
            if (data_a !== fs[i][11:0] || err_a !== (fs[i][15:12] != 4'h0)) begin
                n_fail++;
                $display("FAIL frame_err_data[%0d]: got %h err=%b expected %h err=%b",
                         i, data_a, err_a, fs[i][11:0], (fs[i][15:12] != 4'h0));
            end
            last_done_cyc = cyc;
        end
    endtask

    task automatic test_rate();
        logic [15:0] f;
        bit got;
        for (int i = 0; i < 6; i++) begin
            f = 16'($urandom_range(0, 65535));
            push_frame(f);
            wait_done_a(PERIOD_A + 20, got);
            n_checks++;
            if (!got || cyc - last_done_cyc !== PERIOD_A) begin
                n_fail++;
                $display("FAIL rate_spacing[%0d]: got %0d cycles (done=%b) expected %0d", i, cyc - last_done_cyc, got, PERIOD_A);
            end
            last_done_cyc = cyc;
            n_checks++;
            if (data_a !== f[11:0] || err_a !== (f[15:12] != 4'h0)) begin
                n_fail++;
                $display("FAIL rate_data[%0d]: got %h err=%b expected %h err=%b", i, data_a, err_a, f[11:0], (f[15:12] != 4'h0));
            end
            n_checks++;
            if (ovr_a !== 1'b0) begin
                n_fail++;
                $display("FAIL rate_overrun[%0d]: got %b expected 0", i, ovr_a);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] f;
        bit got;
        int t0;
        push_frame(16'hF5A5);
        wait_cs_low_a(PERIOD_A + 20, got);
        if (got) wait_falls_a(8, 100, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL reset_mid_reach: frame did not reach bit 7 (falls=%0d)", falls_a);
        end
        rst = 1'b1;
        #1;
        n_checks++;
        if ({cs_n_a, sclk_a, busy_a, done_a, data_a} !== {1'b1, 1'b1, 1'b0, 1'b0, 12'h000}) begin
            n_fail++;
            $display("FAIL reset_mid_async: got cs=%b sclk=%b busy=%b done=%b data=%h expected 1 1 0 0 000",
                     cs_n_a, sclk_a, busy_a, done_a, data_a);
        end
        repeat (3) @(negedge clk_50M);
        n_checks++;
        if (done_a !== 1'b0 || cs_n_a !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_mid_hold: got done=%b cs=%b expected 0 1", done_a, cs_n_a);
        end
        f = 16'h0017;
        push_frame(f);
        rst = 1'b0;
        t0  = cyc;
        wait_done_a(LATENCY + 20, got);
        n_checks++;
        if (!got || cyc - t0 !== LATENCY) begin
            n_fail++;
            $display("FAIL reset_mid_latency: got %0d (done=%b) expected %0d", cyc - t0, got, LATENCY);
        end
        n_checks++;
        if (data_a !== f[11:0] || err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid_data: got %h err=%b expected %h err=0", data_a, err_a, f[11:0]);
        end
        last_done_cyc = cyc;
    endtask

    task automatic test_en_drop();
        logic [15:0] f;
        bit got;
        int lows, dones;
        f = 16'($urandom_range(0, 4095));
        push_frame(f);
        wait_cs_low_a(PERIOD_A + 20, got);
        if (got) wait_falls_a(4, 100, got);
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL en_drop_reach: frame did not reach bit 3 (falls=%0d)", falls_a);
        end
        en_a = 1'b0;
        wait_done_a(LATENCY + 20, got);
        n_checks++;
        if (!got || data_a !== f[11:0] || err_a !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_data: got %h err=%b done=%b expected %h err=0 done=1", data_a, err_a, got, f[11:0]);
        end
        n_checks++;
        if (ovr_a !== 1'b0) begin
            n_fail++;
            $display("FAIL en_drop_overrun: got %b expected 0", ovr_a);
        end
        lows  = 0;
        dones = 0;
        for (int n = 0; n < 3 * PERIOD_A; n++) begin
            @(negedge clk_50M);
            if (cs_n_a !== 1'b1) lows++;
            if (done_a !== 1'b0) dones++;
        end
        n_checks++;
        if (lows !== 0 || dones !== 0) begin
            n_fail++;
            $display("FAIL en_drop_quiet: got %0d cs_low and %0d ad_done cycles expected 0 and 0", lows, dones);
        end
    endtask

    task automatic test_avg4();
        logic [15:0] fs [8];
        bit   got;
        int   t0, sum;
        for (int i = 0; i < 4; i++) fs[i] = 16'(i);
        for (int i = 4; i < 8; i++) fs[i] = 16'h0FFF;
        for (int g = 0; g < 2; g++) begin
            sum = 0;
            for (int i = 0; i < 4; i++) begin
                push_frame(fs[g * 4 + i]);
                sum = sum + int'(fs[g * 4 + i][11:0]);
            end
            if (g == 0) begin
                @(negedge clk_50M);
                en_a = 1'b1;
            end
            t0 = (g == 0) ? cyc : last_done_cyc;
            wait_done_a(4 * PERIOD_A + 100, got);
            n_checks++;
            if (!got || cyc - t0 !== ((g == 0) ? 3 * PERIOD_A + LATENCY : 4 * PERIOD_A)) begin
                n_fail++;
                $display("FAIL avg4_timing[%0d]: got %0d cycles (done=%b)", g, cyc - t0, got);
            end
            n_checks++;
            if (data_a !== 12'(sum / 4) || err_a !== 1'b0) begin
                n_fail++;
                $display("FAIL avg4_data[%0d]: got %h err=%b expected %h err=0", g, data_a, err_a, 12'(sum / 4));
            end
            last_done_cyc = cyc;
        end
    endtask

    initial begin
        test_reset();
        test_overrun();
`ifdef ADC_AVG4_EN
        test_avg4();
`else
        test_basic();
        test_frame_err();
        test_rate();
        test_reset_mid();
        test_en_drop();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/adc_spi_capture.md
Name: adc_spi_capture

Overview:
- Front-end stage feeding the UART transmitter. It paces conversions of a 12-bit serial ADC (AD7476-class, 16-bit SPI frame, CPOL=1) at a fixed sample rate and shifts in each result.
- Each sample is presented on ad_data with a one-cycle ad_done strobe, directly compatible with the UART_TX ad_data/ad_done inputs.

Parameters:
- CLK_DIV, 2: clk_50M cycles per SCLK half-period. Default gives 12.5 MHz SCLK. Legal range is ≥1.
- SAMPLE_PERIOD, 50000: clk_50M cycles between conversion starts. Default gives 1 kHz. Must be ≥ 34*CLK_DIV+1+T_QUIET.
- T_QUIET, 4: minimum cycles cs_n stays high after a frame before the next start is accepted.

Ports:
- clk_50M, input, 1: system clock, 50 MHz.
- rst, input, 1: reset. One clock; reset is asynchronous and active-high.
- en, input, 1: continuous sampling enable (level).
- adc_sdo, input, 1: ADC serial data out. Already synchronous to SCLK; not re-synchronised.
- adc_cs_n, output, 1: ADC chip select, active low.
- adc_sclk, output, 1: ADC serial clock, idle high. Driven from a register.
- ad_data, output, 12: last captured sample.
- ad_done, output, 1: one-cycle strobe; ad_data is valid in the same cycle.
- busy, output, 1: high from conversion start until cs_n returns high.
- frame_err, output, 1: high for the current sample if any of the 4 leading frame bits was 1. Updated together with ad_data.
- overrun, output, 1: sticky flag. Set when a sample tick is dropped; cleared only when en=0 or on rst.

Behaviour:
- Reset values: adc_cs_n=1, adc_sclk=1, ad_data=0, ad_done=0, busy=0, frame_err=0, overrun=0. The FSM returns to IDLE and the sample timer is cleared. Reset asserted mid-frame aborts immediately: cs_n and sclk go high asynchronously and no ad_done is produced.
- Sample timer:
  - Counts 0..SAMPLE_PERIOD-1 while en=1 and wraps. The tick is asserted when the count is 0.
  - While en=0 the timer is held at 0, so the first tick occurs in the first cycle en is high.
- FSM states: IDLE → SETUP → SHIFT → HOLD → QUIET → IDLE.
- IDLE:
  - A tick with quiet satisfied moves to SETUP: cs_n falls next cycle and busy=1.
  - A tick arriving in any non-IDLE state is dropped and sets overrun.
- SETUP: lasts CLK_DIV cycles with sclk=1.
- SHIFT:
  - 16 SCLK periods, each with sclk=0 for CLK_DIV cycles, then sclk=1 for CLK_DIV cycles.
  - adc_sdo is sampled in the cycle sclk is driven 0→1 (end of the low half) and shifted into a 16-bit register, MSB first.
  - A 5-bit bit counter runs 0..15.
- HOLD: lasts CLK_DIV cycles with sclk=1, then cs_n=1 and busy=0.
- Result output:
  - In the cycle after cs_n rises: ad_data = shift[11:0], frame_err = |shift[15:12], ad_done=1 for exactly one cycle.
  - ad_data holds until the next ad_done.
- QUIET: holds cs_n high for T_QUIET cycles, then returns to IDLE.
- Latency from tick to ad_done is 34*CLK_DIV+1 cycles; the default is 69.
- en falling mid-frame: the current frame completes and its ad_done is produced. No further starts occur, and overrun is cleared.
- Tick in the same cycle as en rising: the conversion starts, since the timer is 0.

Optional Feature:
- Macro ADC_AVG4_EN.
- Defined:
  - Results are accumulated in a 14-bit sum.
  - ad_done fires on every 4th completed conversion with ad_data = sum[13:2] (truncating) and frame_err = OR of the 4 frames. The sum then clears.
  - en=0 or rst discards a partial accumulation.
- Undefined: every conversion produces ad_done as described above, and no accumulator is synthesised.

Test Plan:
- Basic capture: release rst, en=1, ADC model drives frame 0x0ABC → after 69 cycles, ad_done pulses once, ad_data=12'hABC, frame_err=0. Check 16 sclk falling edges within cs_n low and cs_n low for 34*CLK_DIV cycles.
- Frame error: model drives 0x8123 → ad_data=12'h123 and frame_err=1. The next frame 0x0001 gives ad_data=12'h001 and frame_err=0.
- Rate and overrun: SAMPLE_PERIOD=1000 → ad_done spacing is exactly 1000 cycles and overrun stays 0. Rerun with SAMPLE_PERIOD=60 (illegal) → overrun=1; set en=0 for one cycle → overrun=0.
- Reset mid-frame: assert rst at bit 7 → cs_n=1 and sclk=1 immediately, no ad_done. After release with en=1, a clean frame 0x0017 yields ad_data=12'h017.
- en drop mid-frame: deassert en at bit 3 → the frame completes with one ad_done, then no cs_n activity for 3*SAMPLE_PERIOD cycles.
- ADC_AVG4_EN: frames 0x000,0x001,0x002,0x003 → a single ad_done with ad_data=12'h001. Frames 0xFFF ×4 → ad_data=12'hFFF.
